// File: rtl/sdram_bist_pkg.sv
// Shared types and constants for the SDRAM self-test traffic generator.
package sdram_bist_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Galois right-shift step
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/sdram_bist_lfsr.sv
// 16-bit pattern generator: load with zero-seed fixup, or advance one step.
module sdram_bist_lfsr
  import sdram_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      // an all-zero state would lock the LFSR
      value <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/sdram_bist.sv
// SDRAM bring-up BIST: write an LFSR pattern over 0..ADDR_LAST, read back, compare.
// Optional read watchdog enabled by defining SDRAM_BIST_TIMEOUT_EN.
// Bus handshake: a request (bus_read|bus_write) is held with stable addr/wdata
// until the cycle bus_ready=1; bus_rvalid is only observed while in RD_WAIT.
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int            AW          = 23,
  parameter int            DW          = 16,
  parameter logic [AW-1:0] ADDR_LAST   = {AW{1'b1}},
  parameter int            TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   seed,
  output logic          bus_read,
  output logic          bus_write,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ready,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_exp,
  output logic [DW-1:0] first_err_got,
  output logic          timeout,
  output state_t        dbg_state
);

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q;
  logic [15:0]       seed_q;
  logic [LFSR_W-1:0] lfsr_val, lfsr_seed;
  logic              lfsr_load, lfsr_step;
  logic              addr_clr, addr_inc, stat_clr, rd_done, tmo_hit, mismatch;
  logic              at_last;
  logic [DW-1:0]     rd_data;

  sdram_bist_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (lfsr_seed),
    .value (lfsr_val)
  );

`ifdef SDRAM_BIST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_cnt <= '0;
    else if (state_q != RD_WAIT) tmo_cnt <= '0;
    else                       tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (state_q == RD_WAIT) && !bus_rvalid && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  assign at_last  = (addr_q == ADDR_LAST);
  // a timed-out read compares as if zero was returned
  assign rd_data  = bus_rvalid ? bus_rdata : '0;
  assign mismatch = rd_done && (rd_data != lfsr_val);

  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    lfsr_seed = seed_q;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    stat_clr  = 1'b0;
    rd_done   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = WR;
          lfsr_load = 1'b1;
          lfsr_seed = seed;
          addr_clr  = 1'b1;
          stat_clr  = 1'b1;
        end
      end
      WR: begin
        if (bus_ready) begin
          if (at_last) begin
            state_d   = RD;
            addr_clr  = 1'b1;
            lfsr_load = 1'b1;
          end else begin
            addr_inc  = 1'b1;
            lfsr_step = 1'b1;
          end
        end
      end
      RD: begin
        if (bus_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus_rvalid || tmo_hit) begin
          rd_done = 1'b1;
          if (at_last) begin
            state_d = DONE;
          end else begin
            state_d   = RD;
            addr_inc  = 1'b1;
            lfsr_step = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      seed_q    <= '0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_read  <= (state_d == RD);
      bus_write <= (state_d == WR);
      if (stat_clr)      seed_q <= seed;
      if (addr_clr)      addr_q <= '0;
      else if (addr_inc) addr_q <= addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
      timeout        <= 1'b0;
    end else if (stat_clr) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
      timeout        <= 1'b0;
    end else if (rd_done) begin
      if (tmo_hit) timeout <= 1'b1;
      if (mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) begin
          first_err_addr <= addr_q;
          first_err_exp  <= lfsr_val;
          first_err_got  <= rd_data;
        end
      end
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = lfsr_val;
  assign busy      = (state_q == WR) || (state_q == RD) || (state_q == RD_WAIT);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_count == 16'd0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_bist.sv
// Bench for sdram_bist: ideal/backpressured memory model with read-back faults,
// checked against a pattern and status model derived from the LFSR rule.
module tb_sdram_bist;
  import sdram_bist_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int N  = 16;
  localparam int MAXC = 4000;

  logic          clk, rst_n, start;
  logic [15:0]   seed;
  logic          bus_read, bus_write, bus_ready, bus_rvalid;
  logic [AW-1:0] bus_addr, first_err_addr;
  logic [DW-1:0] bus_wdata, bus_rdata, first_err_exp, first_err_got;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;
  state_t        dbg_state;

  sdram_bist #(.AW(AW), .DW(DW), .ADDR_LAST(8'd15), .TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // model state
  logic [DW-1:0] seq [N];
  logic [DW-1:0] flip [N];
  bit            drop [N];
  logic [DW-1:0] mem  [N];
  logic [DW-1:0] wlog [N];
  logic [DW-1:0] exp_q[$];
  int  wr_idx, rd_idx;
  bit  chk_en, bp_en;
  int  m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_exp, m_got;
  bit  m_tmo;

  function automatic logic [15:0] model_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic prep(input logic [15:0] sd);
    logic [15:0] l;
    l = (sd == 16'h0) ? 16'h0001 : sd;
    exp_q = {};
    for (int i = 0; i < N; i++) begin
      seq[i] = l;
      exp_q.push_back(l);
      l = model_step(l);
    end
    wr_idx = 0; rd_idx = 0;
    m_err = 0; m_addr = '0; m_exp = '0; m_got = '0; m_tmo = 0;
    for (int a = 0; a < N; a++) begin
      if (flip[a] != 0 || drop[a]) begin
        if (m_err == 0) begin
          m_addr = AW'(a);
          m_exp  = seq[a];
          m_got  = drop[a] ? 16'h0000 : (seq[a] ^ flip[a]);
        end
        m_err++;
        if (drop[a]) m_tmo = 1;
      end
    end
  endtask

  // memory responder and ready driver
  initial begin : responder
    bit            s_acc;
    logic [3:0]    s_addr, rv_addr;
    int            rv_cnt;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; rv_cnt = 0; rv_addr = '0;
    forever begin
      @(negedge clk);
      s_acc  = rst_n && bus_read && bus_ready;
      s_addr = bus_addr[3:0];
      if (rst_n && bus_write && bus_ready) mem[bus_addr[3:0]] = bus_wdata;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      if (!rst_n) begin
        rv_cnt = 0;
      end else if (rv_cnt != 0) begin
        rv_cnt--;
        if (rv_cnt == 0 && !drop[rv_addr]) begin
          bus_rvalid = 1'b1;
          bus_rdata  = mem[rv_addr] ^ flip[rv_addr];
        end
      end
      if (s_acc && rst_n) begin rv_cnt = 2; rv_addr = s_addr; end
      bus_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard / compare process
  bit            prev_req, prev_rdy, prev_rd, prev_wr;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (prev_req && !prev_rdy) begin
        chk("hold_req", {30'd0, bus_read, bus_write}, {30'd0, prev_rd, prev_wr});
        chk("hold_addr", 32'(bus_addr), 32'(prev_addr));
        chk("hold_wdata", 32'(bus_wdata), 32'(prev_wdata));
      end
      if (bus_read && bus_write) chk("rd_wr_both", 1, 0);
      if (bus_write && bus_ready) begin
        chk("wr_addr", 32'(bus_addr), 32'(wr_idx));
        if (exp_q.size() == 0) chk("wr_extra", 1, 0);
        else chk("wr_data", 32'(bus_wdata), 32'(exp_q.pop_front()));
        if (wr_idx < N) wlog[wr_idx] = bus_wdata;
        wr_idx++;
      end
      if (bus_read && bus_ready) begin
        chk("rd_addr", 32'(bus_addr), 32'(rd_idx));
        chk("rd_after_wr", 32'(wr_idx), N);
        rd_idx++;
      end
    end
    prev_req   = rst_n && (bus_read || bus_write);
    prev_rdy   = bus_ready;
    prev_rd    = bus_read;
    prev_wr    = bus_write;
    prev_addr  = bus_addr;
    prev_wdata = bus_wdata;
  end

  task automatic pulse_start(input logic [15:0] sd);
    @(negedge clk);
    seed = sd; start = 1'b1; chk_en = 1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", 32'(busy), 1);
    chk("done_clr", 32'(done), 0);
  endtask

  task automatic run_test(input string name, input logic [15:0] sd, input bit bp);
    int c;
    bp_en = bp;
    prep(sd);
    pulse_start(sd);
    for (c = 0; c < MAXC && !done; c++) begin
      @(negedge clk);
      start = (c == 10);
      seed  = 16'h1234;
    end
    start = 1'b0;
    chk({name, "_done"}, 32'(done), 1);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_nwr"}, 32'(wr_idx), N);
    chk({name, "_nrd"}, 32'(rd_idx), N);
    chk({name, "_pass"}, 32'(pass), 32'(m_err == 0));
    chk({name, "_errs"}, 32'(err_count), 32'(m_err));
    chk({name, "_faddr"}, 32'(first_err_addr), 32'(m_addr));
    chk({name, "_fexp"}, 32'(first_err_exp), 32'(m_exp));
    chk({name, "_fgot"}, 32'(first_err_got), 32'(m_got));
    chk({name, "_tmo"}, 32'(timeout), 32'(m_tmo));
    chk_en = 0;
    bp_en  = 0;
  endtask

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin flip[a] = '0; drop[a] = 0; end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_rd"}, 32'(bus_read), 0);
    chk({name, "_wr"}, 32'(bus_write), 0);
    chk({name, "_addr"}, 32'(bus_addr), 0);
    chk({name, "_wdata"}, 32'(bus_wdata), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_pass"}, 32'(pass), 0);
    chk({name, "_errs"}, 32'(err_count), 0);
    chk({name, "_faddr"}, 32'(first_err_addr), 0);
    chk({name, "_fexp"}, 32'(first_err_exp), 0);
    chk({name, "_fgot"}, 32'(first_err_got), 0);
    chk({name, "_tmo"}, 32'(timeout), 0);
    chk({name, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin : main
    int c;
    rst_n = 1'b0; start = 1'b0; seed = '0; chk_en = 0; bp_en = 0;
    clear_faults();
    for (int a = 0; a < N; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("idle");

    // ideal memory, known seed
    run_test("basic", 16'hACE1, 0);
    chk("basic_w0", 32'(wlog[0]), 32'h0000ACE1);
    chk("basic_w1", 32'(wlog[1]), 32'h0000E270);

    // bit0 flips on read of addr 5 and 9
    flip[5] = 16'h0001; flip[9] = 16'h0001;
    run_test("flip", 16'hACE1, 0);
    chk("flip_errs_lit", 32'(err_count), 2);
    chk("flip_faddr_lit", 32'(first_err_addr), 5);
    chk("flip_xor_lit", 32'(first_err_exp ^ first_err_got), 32'h0001);
    chk("flip_pass_lit", 32'(pass), 0);
    clear_faults();

    // random backpressure
    run_test("bp", 16'(($urandom_range(1, 16'hFFFF))), 1);

    // zero seed
    run_test("seed0", 16'h0000, 0);
    chk("seed0_w0", 32'(wlog[0]), 32'h00000001);

    // reset during write phase at addr 7
    prep(16'h5A5A);
    pulse_start(16'h5A5A);
    for (c = 0; c < MAXC && !(bus_write && bus_addr == 8'd7); c++) @(negedge clk);
    chk("mid_reached", 32'(bus_write && bus_addr == 8'd7), 1);
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    chk_zero("midrst_hold");
    rst_n = 1'b1;
    run_test("after_rst", 16'h5A5A, 0);

    // randomized seeds, backpressure and read-back corruption
    for (int t = 0; t < 5; t++) begin
      clear_faults();
      if ($urandom_range(0, 1)) flip[$urandom_range(0, N-1)] = 16'($urandom_range(1, 16'hFFFF));
      if ($urandom_range(0, 1)) flip[$urandom_range(0, N-1)] = 16'($urandom_range(1, 16'hFFFF));
      run_test("rand", 16'($urandom), bit'($urandom_range(0, 1)));
    end
    clear_faults();

`ifdef SDRAM_BIST_TIMEOUT_EN
    drop[3] = 1;
    run_test("tmo", 16'hACE1, 0);
    chk("tmo_flag_lit", 32'(timeout), 1);
    chk("tmo_errs_lit", 32'(err_count), 1);
    chk("tmo_faddr_lit", 32'(first_err_addr), 3);
    chk("tmo_fgot_lit", 32'(first_err_got), 0);
    clear_faults();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_bist.md
Name: sdram_bist

Overview:
Self-test traffic generator that drives the SDRAM controller's system-bus port in place of the JTAG host on the DE2 board. On start it writes a 16-bit LFSR pattern to an address range, then reads the range back and compares. It reports pass/fail, an error count and the first failing address/data, so that SDRAM bring-up at each PLL frequency needs no host.

Parameters:
AW, 23, bus address width (word address)
DW, 16, bus data width; must equal 16 (LFSR width)
ADDR_LAST, 2**AW-1, last address tested; range is 0..ADDR_LAST
TIMEOUT_CYC, 1024, read-data watchdog limit in clk cycles (used only with SDRAM_BIST_TIMEOUT_EN)

Ports:
clk  input  1  system clock (same as SDRAM controller)
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a test when idle/done
seed  input  16  LFSR seed, sampled on accepted start
bus_read  output  1  read request, held until accepted
bus_write  output  1  write request, held until accepted
bus_addr  output  AW  request address
bus_wdata  output  DW  write data
bus_ready  input  1  request accepted this cycle when (read|write)&ready
bus_rvalid  input  1  read data valid
bus_rdata  input  DW  read data
busy  output  1  test running
done  output  1  level; test finished, held until next start
pass  output  1  valid with done; 1 iff err_count==0
err_count  output  16  mismatches, saturates at 16'hFFFF
first_err_addr  output  AW  address of first mismatch
first_err_exp  output  DW  expected data at first mismatch
first_err_got  output  DW  read data at first mismatch
timeout  output  1  sticky; set when any read timed out (0 without macro)

Behaviour:
- Reset: state IDLE; all outputs 0, including bus_read/bus_write, addr, status and capture registers.
- LFSR: Galois, next = (l>>1) ^ (l[0] ? 16'hB400 : 0). Seed 0 is replaced by 16'h0001. From seed 16'hACE1 the sequence is ACE1, E270, ...
- Bus outputs are registered from state; bus_addr/bus_wdata stay stable while a request is pending.
- IDLE/DONE: start=1 -> load lfsr=seed, addr=0, clear err_count/first_err_*/timeout/done, go WR. start ignored in any other state.
- WR: bus_write=1, wdata=lfsr. On ready: if addr==ADDR_LAST then addr=0, lfsr=seed, go RD; else addr++, lfsr advances.
- RD: bus_read=1. On ready -> RD_WAIT, bus_read drops next cycle. One read outstanding at a time.
- RD_WAIT: on rvalid, compare rdata to lfsr. On mismatch, err_count saturating +1; capture first_err_* only when err_count was 0. Then if addr==ADDR_LAST go DONE, else addr++, lfsr advances, go RD.
- DONE: done=1, pass=(err_count==0), busy=0; status held.
- busy=1 in WR, RD, RD_WAIT.
- rvalid outside RD_WAIT is ignored. ready is ignored when no request is driven.
- Reset mid-test aborts immediately to reset values; the bus request drops asynchronously.
- Per-pass latency = (ADDR_LAST+1) writes + (ADDR_LAST+1) reads, each bounded by controller latency.

Optional Feature:
SDRAM_BIST_TIMEOUT_EN.
- Defined: a counter runs in RD_WAIT, cleared on entry. When it reaches TIMEOUT_CYC without rvalid, the read is treated as a mismatch with got=0, timeout is set (sticky), and the block advances as for rvalid. A late rvalid is then ignored.
- Undefined: no counter; RD_WAIT waits indefinitely; timeout tied 0.

Decomposition:
- sdram_bist_pkg: state enum (IDLE, WR, RD, RD_WAIT, DONE), LFSR_POLY=16'hB400, LFSR_W=16.
- Sub-module sdram_bist_lfsr: load/seed-fixup/advance, single-cycle step enable.

Test Plan:
- ADDR_LAST=15, seed=ACE1, ideal memory (ready=1, rvalid 3 cycles after accept) -> 16 writes (addr0 data ACE1, addr1 E270), 16 reads, done=1, pass=1, err_count=0.
- Same, model flips bit0 on read of addr5 and addr9 -> err_count=2, first_err_addr=5, exp^got=0001, pass=0.
- Random ready backpressure (50%) -> addr/wdata/read/write stable while ready=0; result pass=1.
- seed=0000 -> first write data 0001; readback pass=1.
- Assert rst_n low during WR at addr7, then release and start -> outputs zero during reset; full test passes.
- With SDRAM_BIST_TIMEOUT_EN, TIMEOUT_CYC=32, model drops rvalid for addr3 -> timeout=1, err_count=1, first_err_addr=3, got=0000, done=1.
